// File: rtl/sample_stream_fifo.sv
// Parametrised ready/valid show-ahead FIFO with occupancy, almost_full and synchronous flush.
// Optional statistics ports (high_water, xfer_count) are enabled by defining SAMPLE_STREAM_FIFO_STATS_EN.
module sample_stream_fifo #(
   parameter int DATA_WIDTH      = 8,
   parameter int DEPTH           = 4,
   parameter int ALMOST_FULL_LVL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       stream_in_valid,
   output logic                       stream_in_ready,
   input  logic [DATA_WIDTH-1:0]      stream_in_data,
   output logic                       stream_out_valid,
   input  logic                       stream_out_ready,
   output logic [DATA_WIDTH-1:0]      stream_out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       almost_full
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
   ,
   output logic [$clog2(DEPTH):0]     high_water,
   output logic [31:0]                xfer_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LVL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr_reg;
   logic [AW-1:0]         rd_ptr_reg;
   logic [CW-1:0]         count_reg;
   logic [CW-1:0]         count_next;
   logic                  almost_full_reg;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] head_word;

   // Ready depends only on registered occupancy, so a full buffer refuses a push even while popping.
   assign stream_in_ready  = (count_reg != FULL_CNT);
   assign stream_out_valid = (count_reg != '0);
   assign push             = stream_in_valid & stream_in_ready;
   assign pop              = stream_out_valid & stream_out_ready;
   assign head_word        = mem[rd_ptr_reg];
   assign count            = count_reg;
   assign almost_full      = almost_full_reg;

   // Head word is forced to zero when empty so stale storage never leaks out.
   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out_mask
         assign stream_out_data[gi] = head_word[gi] & stream_out_valid;
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      if (flush)
         count_next = '0;
      else if (push && !pop)
         count_next = count_reg + CW'(1);
      else if (!push && pop)
         count_next = count_reg - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr_reg] <= stream_in_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         almost_full_reg <= 1'b0;
      end else begin
         count_reg       <= count_next;
         almost_full_reg <= (count_next >= AF_CNT);
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push)
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

`ifdef SAMPLE_STREAM_FIFO_STATS_EN
   logic [CW-1:0] high_water_reg;
   logic [31:0]   xfer_count_reg;

   // A pop coinciding with flush is overridden, so it is not counted as a transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         high_water_reg <= '0;
         xfer_count_reg <= '0;
      end else begin
         if (flush)
            high_water_reg <= '0;
         else if (count_next > high_water_reg)
            high_water_reg <= count_next;
         if (pop && !flush)
            xfer_count_reg <= xfer_count_reg + 32'd1;
      end
   end

   assign high_water = high_water_reg;
   assign xfer_count = xfer_count_reg;
`endif

endmodule
